// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between an
// instruction-fetch port (I, read-only) and a load/store port (D).
// Requests are serialised with round-robin arbitration. A store takes
// 2 cycles (IDLE, ACCESS). A read takes 3 cycles (IDLE, ACCESS, READ_WAIT).
//
// Handshake: a requester raises *_req_valid and holds it, with stable
// request fields, until *_req_ready is high. *_req_ready is asserted
// combinationally, only in IDLE, for the single granted port. The request
// fields are sampled on the clock edge that ends that ready cycle. Each
// accepted request produces exactly one *_rsp_valid pulse, lasting one
// cycle. There is no response back-pressure. *_rsp_data holds its value
// between pulses.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_req_ready,
    output logic                  i_rsp_valid,
    output logic [DATA_WIDTH-1:0] i_rsp_data,
    input  logic                  d_req_valid,
    input  logic                  d_req_we,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    output logic                  d_req_ready,
    output logic                  d_rsp_valid,
    output logic [DATA_WIDTH-1:0] d_rsp_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        READ_WAIT = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  last_grant_d;  // 1: D was granted last, 0: I
    logic                  grant_d;
    logic                  accept;
    logic                  drive_bus;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  lat_grant_d;

    // The bus is driven only during a store's ACCESS cycle. Every other
    // cycle it is released so that the RAM can drive it.
    assign ram_data  = drive_bus ? lat_wdata : {DATA_WIDTH{1'bz}};
    assign fsm_state = state;

    // Next-state logic, grant selection and the RAM pin controls.
    always_comb begin
        next_state  = state;
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        accept      = 1'b0;
        drive_bus   = 1'b0;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_oe      = 1'b0;
        ram_addr    = '0;
        // On a tie, grant the port that did not win last time.
        grant_d     = d_req_valid && (!i_req_valid || !last_grant_d);
        case (state)
            IDLE: begin
                if (i_req_valid || d_req_valid) begin
                    accept      = 1'b1;
                    i_req_ready = !grant_d;
                    d_req_ready = grant_d;
                    next_state  = ACCESS;
                end
            end
            ACCESS: begin
                ram_cs     = 1'b1;
                ram_addr   = lat_addr;
                ram_we     = lat_we;
                ram_oe     = !lat_we;
                drive_bus  = lat_we;
                next_state = lat_we ? IDLE : READ_WAIT;
            end
            READ_WAIT: begin
                ram_cs     = 1'b1;
                ram_oe     = 1'b1;
                ram_addr   = lat_addr;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                last_grant_d <= grant_d;
            end
        end
    end

    // Request latch and response registers. A reset aborts any in-flight
    // response.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr    <= '0;
            lat_we      <= 1'b0;
            lat_wdata   <= '0;
            lat_grant_d <= 1'b0;
            i_rsp_valid <= 1'b0;
            i_rsp_data  <= '0;
            d_rsp_valid <= 1'b0;
            d_rsp_data  <= '0;
        end else begin
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            if (accept) begin
                lat_addr    <= grant_d ? d_req_addr : i_req_addr;
                lat_we      <= grant_d && d_req_we;
                lat_wdata   <= d_req_wdata;
                lat_grant_d <= grant_d;
            end
            // Only port D can store, so a store ack always goes to D.
            if (state == ACCESS && lat_we) begin
                d_rsp_valid <= 1'b1;
                d_rsp_data  <= '0;
            end
            if (state == READ_WAIT) begin
                if (lat_grant_d) begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_data  <= ram_data;
                end else begin
                    i_rsp_valid <= 1'b1;
                    i_rsp_data  <= ram_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It contains a behavioural single-port
// synchronous RAM and a reference memory model. Expected responses are
// queued when a request is accepted, and a monitor checks them against
// the DUT.
module tb_mem_port_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_valid;
  logic [AW-1:0] i_req_addr;
  logic          i_req_ready;
  logic          i_rsp_valid;
  logic [DW-1:0] i_rsp_data;
  logic          d_req_valid;
  logic          d_req_we;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata;
  logic          d_req_ready;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic [AW-1:0] ram_addr;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;
  wire  [DW-1:0] ram_data;
  logic [1:0]    fsm_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Scoreboard queues: response data, the cycle it is due, and the stores
  // expected on the RAM pins.
  logic [DW-1:0] i_exp_q[$];
  int            i_due_q[$];
  logic [DW-1:0] d_exp_q[$];
  int            d_due_q[$];
  logic [AW-1:0] w_addr_q[$];
  logic [DW-1:0] w_data_q[$];

  // Reference memory: an unwritten word reads as zero.
  logic [DW-1:0] ref_mem [int];

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_data(ram_data), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural RAM ----------------
  logic [DW-1:0] ram_mem [0:255];
  logic [DW-1:0] ram_q;

  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = '0;
    ram_q = '0;
  end

  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_addr[7:0]] <= ram_data;
    else if (ram_cs) ram_q <= ram_mem[ram_addr[7:0]];
  end

  assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : {DW{1'bz}};

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  function automatic logic bus_free(input logic [DW-1:0] v);
    return (v === {DW{1'bz}}) || (v === '0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic i_fetch(input logic [AW-1:0] addr, output int acc);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    acc = -1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (i_req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      check("i_req_timeout", 64'd0, 64'd1);
    end else begin
      i_exp_q.push_back(ref_read(addr));
      i_due_q.push_back(acc + 3);
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic d_access(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output int acc);
    d_req_valid = 1'b1;
    d_req_we    = we;
    d_req_addr  = addr;
    d_req_wdata = wdata;
    acc = -1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (d_req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      check("d_req_timeout", 64'd0, 64'd1);
    end else if (we) begin
      ref_mem[int'(addr)] = wdata;
      d_exp_q.push_back('0);
      d_due_q.push_back(acc + 2);
      w_addr_q.push_back(addr);
      w_data_q.push_back(wdata);
    end else begin
      d_exp_q.push_back(ref_read(addr));
      d_due_q.push_back(acc + 3);
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    d_req_wdata = $urandom;
  endtask

  task automatic drain();
    int left;
    for (int t = 0; t < 40; t++) begin
      left = i_exp_q.size() + d_exp_q.size() + w_addr_q.size();
      if (left == 0) break;
      @(posedge clk);
    end
    left = i_exp_q.size() + d_exp_q.size() + w_addr_q.size();
    check("drain_outstanding", 64'(left), 64'd0);
    #1;
  endtask

  task automatic flush_queues();
    i_exp_q.delete(); i_due_q.delete();
    d_exp_q.delete(); d_due_q.delete();
    w_addr_q.delete(); w_data_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [DW-1:0] last_i;
  logic [DW-1:0] last_d;

  always @(negedge clk) begin
    if (rst) begin
      last_i = '0;
      last_d = '0;
    end else begin
      if (i_rsp_valid) begin
        if (i_exp_q.size() == 0) check("i_unexpected_rsp", 64'd1, 64'd0);
        else begin
          check("i_rsp_data", 64'(i_rsp_data), 64'(i_exp_q.pop_front()));
          check("i_rsp_cycle", 64'(cyc), 64'(i_due_q.pop_front()));
        end
        last_i = i_rsp_data;
      end else begin
        check("i_rsp_hold", 64'(i_rsp_data), 64'(last_i));
      end
      if (d_rsp_valid) begin
        if (d_exp_q.size() == 0) check("d_unexpected_rsp", 64'd1, 64'd0);
        else begin
          check("d_rsp_data", 64'(d_rsp_data), 64'(d_exp_q.pop_front()));
          check("d_rsp_cycle", 64'(cyc), 64'(d_due_q.pop_front()));
        end
        last_d = d_rsp_data;
      end else begin
        check("d_rsp_hold", 64'(d_rsp_data), 64'(last_d));
      end
      check("ready_exclusive", 64'(i_req_ready && d_req_ready), 64'd0);
      check("oe_we_exclusive", 64'(ram_oe && ram_we), 64'd0);
      if (ram_cs && ram_we) begin
        if (w_addr_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
        else begin
          check("write_addr", 64'(ram_addr), 64'(w_addr_q.pop_front()));
          check("write_data", 64'(ram_data), 64'(w_data_q.pop_front()));
        end
      end
      if (!ram_cs) check("bus_released", 64'(bus_free(ram_data)), 64'd1);
    end
  end

  // ---------------- stimulus ----------------
  int acc_a, acc_b;
  int ai[2];
  int ad[2];
  int st[4];
  logic [DW-1:0] val;

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'(fsm_state), 64'd0);
    check("reset_ram_ctl", 64'({ram_cs, ram_we, ram_oe}), 64'd0);
    check("reset_ram_addr", 64'(ram_addr), 64'd0);
    check("reset_rsp_valid", 64'({i_rsp_valid, d_rsp_valid}), 64'd0);
    check("reset_rsp_data", 64'(i_rsp_data | d_rsp_data), 64'd0);
    check("reset_bus", 64'(bus_free(ram_data)), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Store then load on port D.
    d_access(1'b1, 30'd5, 32'hDEADBEEF, acc_a);
    d_access(1'b0, 30'd5, 32'h0, acc_b);
    check("d_store_load_spacing", 64'(acc_b - acc_a), 64'd2);
    drain();

    // Fill 0..15 with random words, then fetch them on port I.
    for (int a = 0; a < 16; a++) d_access(1'b1, AW'(a), $urandom, acc_a);
    for (int a = 0; a < 16; a++) i_fetch(AW'(a), acc_a);
    drain();

    // Tie after reset: D wins first, then grants alternate.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    fork
      begin
        for (int k = 0; k < 2; k++) i_fetch(30'd3, ai[k]);
      end
      begin
        for (int k = 0; k < 2; k++) d_access(1'b0, 30'd7, 32'h0, ad[k]);
      end
    join
    check("tie_d0_to_i0", 64'(ai[0] - ad[0]), 64'd3);
    check("tie_i0_to_d1", 64'(ad[1] - ai[0]), 64'd3);
    check("tie_d1_to_i1", 64'(ai[1] - ad[1]), 64'd3);
    drain();

    // Back-to-back stores.
    for (int k = 0; k < 4; k++) d_access(1'b1, AW'(20 + k), $urandom, st[k]);
    for (int k = 1; k < 4; k++) check("store_spacing", 64'(st[k] - st[k-1]), 64'd2);
    drain();

    // Reset during a fetch's READ_WAIT cycle.
    i_fetch(30'd9, acc_a);
    @(posedge clk); #1;
    check("pre_reset_read_wait", 64'(fsm_state), 64'd2);
    rst = 1'b1;
    flush_queues();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_state_idle", 64'(fsm_state), 64'd0);
    check("abort_ram_cs", 64'(ram_cs), 64'd0);
    check("abort_no_rsp", 64'(i_rsp_valid), 64'd0);
    @(posedge clk); #1;
    i_fetch(30'd9, acc_a);
    drain();

    // Idle: no requests for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_ram_ctl", 64'({ram_cs, ram_we, ram_oe}), 64'd0);
      check("idle_ready", 64'({i_req_ready, d_req_ready}), 64'd0);
      check("idle_bus", 64'(bus_free(ram_data)), 64'd1);
    end
    @(posedge clk); #1;

    // Random concurrent traffic on both ports.
    fork
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          i_fetch(AW'($urandom_range(0, 31)), acc_a);
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          val = $urandom;
          d_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), val, acc_b);
        end
      end
    join
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
